// File: rtl/page_alloc.sv
// rtl/page_alloc.sv - two-level bitmap free-page allocator, lowest-free-first,
// with NFREE round-robin free channels and double/bad free detection.
module page_alloc #(
  parameter int PAGE_W     = 15,
  parameter int WORD_W     = 32,
  parameter int FIRST_PAGE = 'h0c00,
  parameter int NFREE      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alloc_req,
  output logic                    alloc_gnt,
  output logic [PAGE_W-1:0]       alloc_page,
  input  logic [NFREE-1:0]        free_req,
  input  logic [NFREE*PAGE_W-1:0] free_page,
  output logic [NFREE-1:0]        free_gnt,
  output logic                    double_free_error,
  output logic                    bad_free_error,
  output logic [PAGE_W-1:0]       err_page,
  output logic [2:0]              err_who,
  output logic [PAGE_W:0]         count,
  output logic                    ready
);
  localparam int BIT_W = $clog2(WORD_W);
  localparam int IDX_W = PAGE_W - BIT_W;
  localparam int DEPTH = (1 << PAGE_W) / WORD_W;
  localparam logic [PAGE_W-1:0] FIRST_P   = PAGE_W'(FIRST_PAGE);
  localparam logic [PAGE_W:0]   FREE_INIT = (PAGE_W+1)'((1 << PAGE_W) - FIRST_PAGE);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RD, S_WR} state_t;
  state_t state;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rd_data;
  logic [DEPTH-1:0]  summary;
  logic [IDX_W-1:0]  init_idx;
  logic [WORD_W-1:0] init_word;

  logic              op_alloc;
  logic [2:0]        op_ch;
  logic [PAGE_W-1:0] op_page;
  logic [IDX_W-1:0]  op_idx;
  logic [WORD_W-1:0] wr_word;
  logic              wr_pend;
  logic              last_alloc;
  logic [2:0]        last_ch;

  logic [IDX_W-1:0]  pe_idx;
  logic [IDX_W-1:0]  sel_idx;
  logic [PAGE_W-1:0] sel_page;
  logic [2:0]        pick_ch, hi_ch, lo_ch;
  logic              hi_found, alloc_cand, free_cand, pick_alloc;
  logic [BIT_W-1:0]  low_bit;
  logic [WORD_W-1:0] cleared_word, set_word;

  always_comb begin
    init_word = '0;
    for (int b = 0; b < WORD_W; b++)
      init_word[b] = (int'(init_idx) * WORD_W + b) >= FIRST_PAGE;
  end

  always_comb begin
    pe_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (summary[i]) pe_idx = IDX_W'(i);
  end

  // Round-robin: lowest requesting channel above the last grant, else wrap to the lowest.
  always_comb begin
    hi_found = 1'b0;
    hi_ch    = '0;
    lo_ch    = '0;
    for (int c = NFREE-1; c >= 0; c--) begin
      if (free_req[c]) begin
        lo_ch = 3'(c);
        if (c > int'(last_ch)) begin
          hi_found = 1'b1;
          hi_ch    = 3'(c);
        end
      end
    end
    pick_ch = hi_found ? hi_ch : lo_ch;
  end

  always_comb begin
    sel_page = '0;
    for (int c = 0; c < NFREE; c++)
      if (pick_ch == 3'(c)) sel_page = free_page[c*PAGE_W +: PAGE_W];
  end

  assign alloc_cand = alloc_req && (|summary);
  assign free_cand  = |free_req;
  assign pick_alloc = alloc_cand && (!free_cand || !last_alloc);
  assign sel_idx    = pick_alloc ? pe_idx : sel_page[PAGE_W-1:BIT_W];

  always_comb begin
    low_bit = '0;
    for (int b = WORD_W-1; b >= 0; b--)
      if (rd_data[b]) low_bit = BIT_W'(b);
  end

  assign cleared_word = rd_data & ~(WORD_W'(1) << low_bit);
  assign set_word     = rd_data | (WORD_W'(1) << op_page[BIT_W-1:0]);

  always_ff @(posedge clk) begin
    if (state == S_INIT)
      mem[init_idx] <= init_word;
    else if (state == S_WR && wr_pend)
      mem[op_idx] <= wr_word;
    rd_data <= mem[sel_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= S_INIT;
      init_idx          <= '0;
      summary           <= '0;
      op_alloc          <= 1'b0;
      op_ch             <= '0;
      op_page           <= '0;
      op_idx            <= '0;
      wr_word           <= '0;
      wr_pend           <= 1'b0;
      last_alloc        <= 1'b0;
      last_ch           <= '0;
      alloc_gnt         <= 1'b0;
      alloc_page        <= '0;
      free_gnt          <= '0;
      double_free_error <= 1'b0;
      bad_free_error    <= 1'b0;
      err_page          <= '0;
      err_who           <= '0;
      count             <= '0;
      ready             <= 1'b0;
    end else begin
      alloc_gnt         <= 1'b0;
      free_gnt          <= '0;
      double_free_error <= 1'b0;
      bad_free_error    <= 1'b0;
      case (state)
        S_INIT: begin
          summary[init_idx] <= |init_word;
          init_idx          <= init_idx + 1'b1;
          if (init_idx == IDX_W'(DEPTH-1)) begin
            state <= S_IDLE;
            ready <= 1'b1;
            count <= FREE_INIT;
          end
        end
        S_IDLE: begin
          if (alloc_cand || free_cand) begin
            op_alloc   <= pick_alloc;
            op_ch      <= pick_ch;
            op_page    <= sel_page;
            op_idx     <= sel_idx;
            last_alloc <= pick_alloc;
            if (!pick_alloc) last_ch <= pick_ch;
            state <= S_RD;
          end
        end
        S_RD: begin
          wr_pend <= 1'b0;
          if (op_alloc) begin
            wr_word    <= cleared_word;
            wr_pend    <= 1'b1;
            alloc_gnt  <= 1'b1;
            alloc_page <= {op_idx, low_bit};
            if (cleared_word == '0) summary[op_idx] <= 1'b0;
            count <= count - 1'b1;
          end else begin
            free_gnt <= NFREE'(1) << op_ch;
            if (op_page < FIRST_P) begin
              bad_free_error <= 1'b1;
              err_page       <= op_page;
              err_who        <= op_ch;
            end else if (rd_data[op_page[BIT_W-1:0]]) begin
              double_free_error <= 1'b1;
              err_page          <= op_page;
              err_who           <= op_ch;
            end else begin
              wr_word          <= set_word;
              wr_pend          <= 1'b1;
              summary[op_idx]  <= 1'b1;
              count            <= count + 1'b1;
            end
          end
          state <= S_WR;
        end
        default: begin
          wr_pend <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end
endmodule
